// File: rtl/switch_led_sequencer_if.sv
// Board-side bundle for switch_led_sequencer: raw switches and mode button in, LED drive and mode out.
interface switch_led_sequencer_if;
  logic [15:0] SW;
  logic        BTN_MODE;
  logic [15:0] LED;
  logic [1:0]  MODE;

  modport master (output SW, output BTN_MODE, input LED, input MODE);
  modport slave  (input SW, input BTN_MODE, output LED, output MODE);
endinterface

// File: rtl/switch_led_sequencer.sv
// Switch/LED controller: synchronised, debounced switches and mode button feed a PASS/WALK/HOLD FSM.
// Build macro SWLED_BOUNCE_EN turns the WALK wrap pattern into a ping-pong one-hot.

module switch_led_sequencer_debounce #(
  parameter int WIDTH      = 1,
  parameter int DEB_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] raw_i,
  output logic [WIDTH-1:0] deb_o
);
  localparam int CW = $clog2(DEB_CYCLES) + 1;
  localparam logic [CW-1:0] CntMax = CW'(DEB_CYCLES - 1);

  logic [WIDTH-1:0] sync1_q, sync2_q, prev_q;
  logic [WIDTH-1:0] deb_q, deb_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  // Any bounce in the synchronised sample restarts the stability count.
  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    if ((sync2_q == prev_q) && (sync2_q != deb_q)) begin
      if (cnt_q == CntMax) begin
        deb_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      deb_q   <= '0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
    end
  end

  assign deb_o = deb_q;
endmodule

module switch_led_sequencer #(
  parameter int DEB_CYCLES = 4,
  parameter int TICK_DIV   = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  switch_led_sequencer_if.slave   bus
);
  typedef enum logic [1:0] {
    ModePass    = 2'b00,
    ModeWalk    = 2'b01,
    ModeHold    = 2'b10,
    ModeIllegal = 2'b11
  } mode_e;

  localparam int TW = $clog2(TICK_DIV + 1);
  localparam logic [TW-1:0] TickMax = TW'(TICK_DIV - 1);

  logic [15:0]   swDeb;
  logic          btnDeb;
  logic          btnDebPrev_q;
  logic          pressPulse;
  mode_e         state_q, state_d;
  logic [15:0]   led_q, led_d;
  logic [TW-1:0] tick_q, tick_d;
`ifdef SWLED_BOUNCE_EN
  logic          dirRight_q, dirRight_d;
`endif

  switch_led_sequencer_debounce #(.WIDTH(16), .DEB_CYCLES(DEB_CYCLES)) u_swDeb (
    .clk   (clk),
    .rst_n (rst_n),
    .raw_i (bus.SW),
    .deb_o (swDeb)
  );

  switch_led_sequencer_debounce #(.WIDTH(1), .DEB_CYCLES(DEB_CYCLES)) u_btnDeb (
    .clk   (clk),
    .rst_n (rst_n),
    .raw_i (bus.BTN_MODE),
    .deb_o (btnDeb)
  );

  assign pressPulse = btnDeb & ~btnDebPrev_q;

  // A press always wins over a coincident WALK tick: the LED update is keyed on the next mode.
  always_comb begin
    state_d = state_q;
    led_d   = led_q;
    tick_d  = tick_q;
`ifdef SWLED_BOUNCE_EN
    dirRight_d = dirRight_q;
`endif
    case (state_q)
      ModePass: if (pressPulse) state_d = ModeWalk;
      ModeWalk: if (pressPulse) state_d = ModeHold;
      ModeHold: if (pressPulse) state_d = ModePass;
      default:  state_d = ModePass;
    endcase

    if (state_d == ModePass) begin
      led_d = swDeb;
    end else if ((state_q != ModeWalk) && (state_d == ModeWalk)) begin
      tick_d = '0;
`ifdef SWLED_BOUNCE_EN
      led_d      = 16'h0001;
      dirRight_d = 1'b0;
`else
      led_d = 16'h0000;
`endif
    end else if ((state_q == ModeWalk) && (state_d == ModeWalk)) begin
      if (tick_q == TickMax) begin
        tick_d = '0;
`ifdef SWLED_BOUNCE_EN
        if (!dirRight_q) begin
          if (led_q[15]) begin
            led_d      = {1'b0, led_q[15:1]};
            dirRight_d = 1'b1;
          end else begin
            led_d = {led_q[14:0], 1'b0};
          end
        end else begin
          if (led_q[0]) begin
            led_d      = {led_q[14:0], 1'b0};
            dirRight_d = 1'b0;
          end else begin
            led_d = {1'b0, led_q[15:1]};
          end
        end
`else
        led_d = (led_q == 16'h0000) ? 16'h0001 : {led_q[14:0], 1'b0};
`endif
      end else begin
        tick_d = tick_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ModePass;
      led_q        <= 16'h0000;
      tick_q       <= '0;
      btnDebPrev_q <= 1'b0;
`ifdef SWLED_BOUNCE_EN
      dirRight_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      led_q        <= led_d;
      tick_q       <= tick_d;
      btnDebPrev_q <= btnDeb;
`ifdef SWLED_BOUNCE_EN
      dirRight_q   <= dirRight_d;
`endif
    end
  end

  assign bus.LED  = led_q;
  assign bus.MODE = state_q;
endmodule
